// File: rtl/serial_mag_comp_pkg.sv
// Shared types for the bit-serial magnitude comparator.
// Provides the controller state encoding, the sticky decision encoding and a
// helper that turns a decision into the (greater, lesser, equal) one-hot.
package serial_mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    GT = 2'd1,
    LT = 2'd2
  } dec_t;

  // Returns {greater, lesser, equal}; exactly one bit is set for any legal decision.
  function automatic logic [2:0] dec_onehot(input dec_t d);
    logic [2:0] r;
    r = 3'b001;
    case (d)
      GT:      r = 3'b100;
      LT:      r = 3'b010;
      default: r = 3'b001;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/serial_mag_comp_if.sv
// Request/result bundle of the bit-serial magnitude comparator.
// master: drives start and operands, observes results (control logic / bench).
// slave : the comparator itself.
//   start      request pulse, sampled only while the comparator is idle
//   a_in/b_in  unsigned operands captured on acceptance
//   busy       high from the cycle after acceptance through the done cycle
//   done       one-cycle pulse, result outputs valid in that cycle
//   greater/lesser/equal  one-hot result, held until the next completion
//   cycles     bit positions examined for the last result
interface serial_mag_comp_if #(
  parameter int WIDTH = 8
) ();
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             greater;
  logic             lesser;
  logic             equal;
  logic [CW-1:0]    cycles;

  modport master (
    output start, a_in, b_in,
    input  busy, done, greater, lesser, equal, cycles
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, greater, lesser, equal, cycles
  );

endinterface

// File: rtl/serial_mag_comp_cell.sv
// Single-bit comparator cell (purely combinational).
//   a, b  input bits
//   gt    a > b
//   lt    a < b
//   eq    a == b
module cmp_bit_cell (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt,
  output logic eq
);

  assign gt = a & ~b;
  assign lt = ~a & b;
  assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial WIDTH-bit unsigned magnitude comparator.
// Operands are captured on an accepted start and shifted MSB-first through a
// single cmp_bit_cell. The first unequal bit fixes the decision; with
// EARLY_EXIT=1 the scan stops there, otherwise all WIDTH bits are scanned.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  serial_mag_comp_if slave port (start/a_in/b_in in, results out)
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  serial_mag_comp_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  dec_t             dec, dec_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    examined;

  logic             busy_q, done_q;
  logic             greater_q, lesser_q, equal_q;
  logic [CW-1:0]    cycles_q;

  logic             cell_gt, cell_lt, cell_eq;

  cmp_bit_cell u_cell (
    .a  (sa[WIDTH-1]),
    .b  (sb[WIDTH-1]),
    .gt (cell_gt),
    .lt (cell_lt),
    .eq (cell_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The decision is sticky: only the first unequal bit may set it.
  always_comb begin
    state_nxt = state;
    dec_nxt   = dec;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        if (dec == EQ && !cell_eq) begin
          if (cell_gt)      dec_nxt = GT;
          else if (cell_lt) dec_nxt = LT;
        end
        if (cnt == CW'(1) || (EARLY_EXIT != 0 && dec == EQ && dec_nxt != EQ))
          state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // busy/done are registered copies of the state, so they lag it by one
  // cycle; the result registers only change on the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      examined  <= '0;
      dec       <= EQ;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      greater_q <= 1'b0;
      lesser_q  <= 1'b0;
      equal_q   <= 1'b0;
      cycles_q  <= '0;
    end else begin
      busy_q <= (state != IDLE);
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa       <= bus.a_in;
            sb       <= bus.b_in;
            cnt      <= CW'(WIDTH);
            examined <= '0;
            dec      <= EQ;
          end
        end
        RUN: begin
          sa       <= sa << 1;
          sb       <= sb << 1;
          cnt      <= cnt - CW'(1);
          examined <= examined + CW'(1);
          dec      <= dec_nxt;
        end
        DONE: begin
          {greater_q, lesser_q, equal_q} <= dec_onehot(dec);
          cycles_q <= examined;
        end
        default: begin
          dec <= EQ;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.greater = greater_q;
  assign bus.lesser  = lesser_q;
  assign bus.equal   = equal_q;
  assign bus.cycles  = cycles_q;

endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
Bit-serial N-bit magnitude comparator. It is the downstream consumer of the single-bit comparator cell. Operands are captured on a start pulse and shifted MSB-first through one bit-compare cell, one bit per cycle. The first unequal bit decides greater or lesser; equal is reported only if all bits match. Results are presented with a done pulse for control logic such as sorters and threshold checkers.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
EARLY_EXIT, 1, 1 = finish on the first unequal bit; 0 = always scan all WIDTH bits (fixed latency).
CW, $clog2(WIDTH+1), width of the bit counter and the cycles output (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a_in  input  WIDTH  operand A, unsigned; captured when start is accepted
b_in  input  WIDTH  operand B, unsigned; captured when start is accepted
busy  output  1  high from the cycle after acceptance through the DONE cycle
done  output  1  one-cycle pulse; the result outputs are valid in that cycle
greater  output  1  A > B
lesser  output  1  A < B
equal  output  1  A == B
cycles  output  CW  number of bit positions examined for the last result

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values, taken at the first rising edge with rst=1 in any state: state=IDLE; busy=0, done=0, greater=0, lesser=0, equal=0, cycles=0; shift registers and counter cleared.
- Reset mid-operation: abort with no done pulse; the previous result is cleared.
- All outputs are registered.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → load sa=a_in, sb=b_in, cnt=WIDTH, dec=EQ, go to RUN.
  - start=0 → stay in IDLE.
- RUN, each cycle:
  - The cell compares sa[WIDTH-1] with sb[WIDTH-1].
  - Shift sa and sb left by 1 (zero fill), decrement cnt, increment the examined count.
  - If dec==EQ and the cell reports greater or lesser, dec takes that value. Once set, dec is never overwritten by later bits.
  - Exit to DONE when cnt==1, or when EARLY_EXIT=1 and dec becomes non-EQ this cycle.
- DONE, one cycle:
  - done=1; greater/lesser/equal decoded from dec (exactly one high); cycles = examined count.
  - Next state is IDLE.
- start in RUN or DONE is ignored (not queued). start in IDLE on the cycle after DONE is accepted, giving back-to-back operation with one idle cycle.
- Latency, with start sampled at edge k:
  - Full scan: done high after edge k+WIDTH+1.
  - Early exit at bit position j (0 = MSB): done high after edge k+j+2.
- greater/lesser/equal/cycles hold their last values until the next DONE. They are stable while busy. They are 0 only after reset, before the first completion.
- Operands are unsigned. No arithmetic beyond the CW-bit counter, which cannot overflow because it is at most WIDTH.

Decomposition:
- Package serial_mag_comp_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Decision enum {EQ, GT, LT}.
  - Function decoding a decision to the (greater, lesser, equal) one-hot.
- Sub-module cmp_bit_cell (1-bit, combinational):
  - Inputs a, b; outputs gt = a&~b, lt = ~a&b, eq = ~(a^b).
  - Instantiated once on the MSB of the shift registers.

Test Plan:
1. WIDTH=8, EARLY_EXIT=1, a=0xA5, b=0xA5, 1-cycle start → done 9 cycles after the start edge; equal=1, greater=0, lesser=0, cycles=8; busy high for exactly 9 cycles.
2. EARLY_EXIT=1, a=0x80, b=0x7F → done 2 cycles after start; greater=1, cycles=1. Then a=0x12, b=0x13 → lesser=1, cycles=8.
3. EARLY_EXIT=0, a=0x80, b=0x7F → done after 9 cycles; greater=1 (later bits favouring B do not override); cycles=8.
4. Start a=0x40, b=0x20; hold start high with a=0x01, b=0xFF through RUN → exactly one done, greater=1. A second op is accepted only in IDLE after DONE.
5. a=0xF0, b=0xF1, assert rst for 1 cycle at the 4th RUN cycle → all outputs 0 after that edge; no done for 20 cycles. Then a=0x03, b=0x03 completes with equal=1.
6. WIDTH=2 boundary: all 16 (a,b) pairs back-to-back → each result matches the reference compare; exactly one of greater/lesser/equal high per done.
